// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: stores a pixel stream row-major into a frame buffer, with optional background clear first
module frame_buffer_writer #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int MAX_PIXELS = 76800
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic              CLEAR_EN,
  input  logic [DATA_W-1:0] CLEAR_VAL,
  input  logic [9:0]        IMG_WIDTH_IN,
  input  logic [8:0]        IMG_HEIGHT_IN,
  input  logic [DATA_W-1:0] PIX_DATA,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  typedef enum logic [1:0] {IDLE, CLEAR, WRITE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, w_addr_q, w_addr_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d, w_data_q, w_data_d;
  logic [9:0] col_q, col_d, width_q, width_d;
  logic [8:0] row_q, row_d, height_q, height_d;
  logic clr_en_q, clr_en_d, w_en_q, w_en_d, done_q, done_d, err_q, err_d;
  logic [18:0] prod;
  logic bad, last, col_end, clr_end;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    width_d   = width_q;
    height_d  = height_q;
    clr_en_d  = clr_en_q;
    clr_val_d = clr_val_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_en_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    prod      = {9'd0, IMG_WIDTH_IN} * {10'd0, IMG_HEIGHT_IN};
    bad       = IMG_WIDTH_IN == 10'd0 || IMG_HEIGHT_IN == 9'd0 || 32'(prod) > 32'(MAX_PIXELS);
    col_end   = col_q == width_q - 10'd1;
    last      = col_end && row_q == height_q - 9'd1;
    clr_end   = addr_q == ADDR_W'(MAX_PIXELS - 1);
    if (state_q == IDLE && START) begin
      width_d   = IMG_WIDTH_IN;
      height_d  = IMG_HEIGHT_IN;
      clr_en_d  = CLEAR_EN;
      clr_val_d = CLEAR_VAL;
      addr_d    = '0;
      col_d     = '0;
      row_d     = '0;
      err_d     = bad;
      state_d   = bad ? IDLE : (clr_en_d ? CLEAR : WRITE);
    end else if (state_q == CLEAR) begin
      w_en_d   = 1'b1;
      w_addr_d = addr_q;
      w_data_d = clr_val_q;
      addr_d   = clr_end ? '0 : addr_q + ADDR_W'(1);
      state_d  = clr_end ? WRITE : CLEAR;
    end else if (state_q == WRITE && PIX_VALID) begin
      w_en_d   = 1'b1;
      w_addr_d = addr_q;
      w_data_d = PIX_DATA;
      done_d   = last;
      state_d  = last ? IDLE : WRITE;
      addr_d   = last ? '0 : addr_q + ADDR_W'(1);
      col_d    = col_end ? '0 : col_q + 10'd1;
      row_d    = last ? '0 : (col_end ? row_q + 9'd1 : row_q);
    end
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      clr_en_q  <= 1'b0;
      clr_val_q <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_en_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      width_q   <= width_d;
      height_q  <= height_d;
      clr_en_q  <= clr_en_d;
      clr_val_q <= clr_val_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_en_q    <= w_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign PIX_READY = state_q == WRITE;
  assign BUSY      = state_q != IDLE;
  assign W_ADDR    = w_addr_q;
  assign W_DATA    = w_data_q;
  assign W_EN      = w_en_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: random-stimulus scoreboard bench for frame_buffer_writer
module tb_frame_buffer_writer;
  localparam int MAXP = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear_en = 1'b0, pix_valid = 1'b0;
  logic [7:0] clear_val = '0, pix_data = '0;
  logic [9:0] img_w = '0;
  logic [8:0] img_h = '0;
  logic pix_ready, w_en, busy, done, err;
  logic [16:0] w_addr;
  logic [7:0] w_data;
  logic [25:0] sb[$];
  int checks = 0, passed = 0;
  frame_buffer_writer #(.ADDR_W(17), .DATA_W(8), .MAX_PIXELS(MAXP)) dut (
    .CLOCK(clk), .RESET(rst), .START(start), .CLEAR_EN(clear_en), .CLEAR_VAL(clear_val),
    .IMG_WIDTH_IN(img_w), .IMG_HEIGHT_IN(img_h), .PIX_DATA(pix_data), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready), .W_ADDR(w_addr), .W_DATA(w_data), .W_EN(w_en), .BUSY(busy),
    .DONE(done), .ERR(err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask
  // monitor: every write is matched against the next expected {addr, data, done}
  always @(posedge clk) begin
    #1;
    if (w_en) begin
      if (sb.size() == 0) chk("unexpected_write", {w_addr, w_data, done}, 32'hFFFF_FFFF);
      else chk("write", {w_addr, w_data, done}, sb.pop_front());
    end else if (done) chk("done_without_write", 32'(done), 0);
  end
  task automatic run_frame(int w, int h, bit clr, logic [7:0] cv, int mode, bit inj, int stop_at, bit seq);
    logic [7:0] pix[$];
    int n = w * h, i = 0, cyc = 0;
    bit injected = 0;
    for (int k = 0; k < n; k++) pix.push_back(seq ? 8'(8'h10 + k) : 8'($urandom_range(0, 255)));
    if (clr) for (int a = 0; a < MAXP; a++) sb.push_back({17'(a), cv, 1'b0});
    for (int k = 0; k < n; k++) sb.push_back({17'(k), pix[k], k == n - 1});
    @(negedge clk);
    start = 1; img_w = 10'(w); img_h = 9'(h); clear_en = clr; clear_val = cv;
    while (i < n && (stop_at == 0 || i < stop_at)) begin
      @(negedge clk);
      start = 0;
      if (inj && !injected && i == 2) begin
        start = 1; img_w = 10'd8; injected = 1;
      end
      pix_valid = mode == 0 ? 1'b1 : (mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1)));
      pix_data = pix[i];
      #4;
      if (pix_valid && pix_ready) i++;
      cyc++;
      if (cyc > MAXP + 20 * n + 50) begin
        chk("frame_timeout", 32'(i), 32'(n));
        break;
      end
    end
    if (stop_at != 0) return;
    @(negedge clk);
    start = 0; pix_valid = 1; pix_data = 8'hEE;
    #4 chk("ready_after_last", 32'(pix_ready), 0);
    @(negedge clk);
    #4 chk("ready_after_last2", 32'(pix_ready), 0);
    @(negedge clk);
    pix_valid = 0;
    chk("busy_after_frame", 32'(busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask
  task automatic reject(int w, int h);
    @(negedge clk);
    start = 1; img_w = 10'(w); img_h = 9'(h); clear_en = 0;
    @(negedge clk);
    start = 0;
    chk("err_pulse", {30'd0, err, busy}, 32'b10);
    @(negedge clk);
    chk("err_clear", {30'd0, err, busy}, 32'b00);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_outputs", {22'd0, w_addr[0], w_data[0], w_en, busy, done, err, pix_ready, w_addr == 0, w_data == 0, 1'b0}, 32'b0000000110);
    run_frame(4, 3, 0, 8'h00, 0, 0, 0, 1);
    run_frame(4, 3, 0, 8'h00, 1, 0, 0, 1);
    run_frame(2, 2, 1, 8'hFF, 2, 0, 0, 0);
    reject(0, 3);
    reject(5, 0);
    reject(320, 241);
    reject(1, MAXP + 1);
    run_frame(4, 4, 0, 8'h00, 2, 0, 0, 0);
    run_frame(1, MAXP, 1, 8'h5A, 2, 0, 0, 0);
    run_frame(4, 3, 0, 8'h00, 0, 0, 5, 0);
    @(negedge clk);
    rst = 1; pix_valid = 0;
    @(negedge clk);
    rst = 0;
    chk("reset_mid_frame", {29'd0, w_en, busy, pix_ready}, 0);
    sb.delete();
    run_frame(4, 3, 0, 8'h00, 2, 0, 0, 0);
    run_frame(4, 3, 0, 8'h00, 0, 1, 0, 0);
    for (int r = 0; r < 6; r++) begin
      int w = $urandom_range(1, 8);
      run_frame(w, $urandom_range(1, MAXP / w), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2, 0, 0, 0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
